// File: rtl/dilithium_pkg.sv
// Shared constants, codes and state encoding for the
// SampleInBall challenge-polynomial engine.
package dilithium_pkg;

  localparam int N      = 256;
  localparam int IDX_W  = 8;
  localparam int SB_DEF = 8;
  localparam int TAU44  = 39;
  localparam int TAU65  = 49;
  localparam int TAU87  = 60;
  localparam int Q_DEF  = 8380417;
  localparam int CNT_W  = 9;

  localparam logic [1:0] LVL_44  = 2'b00;
  localparam logic [1:0] LVL_65  = 2'b01;
  localparam logic [1:0] LVL_87  = 2'b10;
  localparam logic [1:0] LVL_BAD = 2'b11;

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIGN,
    S_SAMPLE,
    S_DONE
  } sib_state_e;

endpackage

// File: rtl/sib_coeff_array.sv
// N x 2-bit ternary coefficient store with bulk clear,
// Fisher-Yates swap write and asynchronous read.
module sib_coeff_array
  import dilithium_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_i,
  input  logic [IDX_W-1:0] i_wr_j,
  input  logic [1:0]       i_sign,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [1:0]       o_rd_code
);

  logic [1:0] r_c [N];

  // Swap step: c[i] takes old c[j], then c[j] takes the sign.
  // The later assignment wins when i == j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N; a++) r_c[a] <= T_ZERO;
    end else if (i_clr) begin
      for (int a = 0; a < N; a++) r_c[a] <= T_ZERO;
    end else if (i_we) begin
      r_c[i_wr_i] <= r_c[i_wr_j];
      r_c[i_wr_j] <= i_sign;
    end
  end

  assign o_rd_code = r_c[i_rd_addr];

endmodule

// File: rtl/sample_in_ball_core.sv
// SampleInBall engine: sign prefix capture, rejection-sampled
// Fisher-Yates placement of tau +/-1 coefficients.
module sample_in_ball_core
  import dilithium_pkg::*;
#(
  parameter  int SIGN_BYTES = SB_DEF,
  parameter  int TAU_L0     = TAU44,
  parameter  int TAU_L1     = TAU65,
  parameter  int TAU_L2     = TAU87,
  parameter  int OUT_FMT    = 0,
  parameter  int Q          = Q_DEF,
  localparam int OUT_W      = (OUT_FMT != 0) ? 23 : 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       ml_dsa_level,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [OUT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int H_W  = 8 * SIGN_BYTES;
  localparam int HI_W = $clog2(H_W);
  localparam int SB_W = (SIGN_BYTES > 1) ? $clog2(SIGN_BYTES) : 1;

  sib_state_e       r_state;
  logic [H_W-1:0]   r_h;
  logic [SB_W-1:0]  r_sb;
  logic [CNT_W-1:0] r_k;
  logic [CNT_W-1:0] r_tau;
  logic             r_err;

  logic             w_fire;
  logic             w_take;
  logic             w_clr;
  logic [CNT_W-1:0] w_i;
  logic [CNT_W-1:0] w_j;
  logic [CNT_W-1:0] w_tau_sel;
  logic [1:0]       w_sign;
  logic [1:0]       w_code;

  assign in_ready = (r_state == S_SIGN) || (r_state == S_SAMPLE);
  assign busy     = in_ready;
  assign done     = (r_state == S_DONE);
  assign err      = r_err;

  assign w_fire = in_valid & in_ready;
  assign w_i    = CNT_W'(N) - r_tau + r_k;
  assign w_j    = {1'b0, in_byte};
  assign w_take = (r_state == S_SAMPLE) & w_fire & ~abort
                & (w_j <= w_i);
  assign w_clr  = (r_state == S_IDLE) & start & ~abort
                & (ml_dsa_level != LVL_BAD);
  assign w_sign = r_h[r_k[HI_W-1:0]] ? T_NEG : T_POS;

  // Level decode to tau.
  always_comb begin
    w_tau_sel = CNT_W'(TAU_L0);
    unique case (1'b1)
      (ml_dsa_level == LVL_65): w_tau_sel = CNT_W'(TAU_L1);
      (ml_dsa_level == LVL_87): w_tau_sel = CNT_W'(TAU_L2);
      default:                  w_tau_sel = CNT_W'(TAU_L0);
    endcase
  end

  // Job sequencing, sign capture and accepted-index counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_sb    <= '0;
      r_k     <= '0;
      r_tau   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              if (ml_dsa_level == LVL_BAD) begin
                r_err <= 1'b1;
              end else begin
                r_tau   <= w_tau_sel;
                r_k     <= '0;
                r_sb    <= '0;
                r_state <= S_SIGN;
              end
            end
          end
          S_SIGN: begin
            if (w_fire) begin
              r_h  <= {in_byte, r_h[H_W-1:8]};
              r_sb <= r_sb + 1'b1;
              if (r_sb == SB_W'(SIGN_BYTES - 1)) begin
                r_k     <= '0;
                r_state <= S_SAMPLE;
              end
            end
          end
          S_SAMPLE: begin
            if (w_take) begin
              r_k <= r_k + 1'b1;
              if (r_k == r_tau - CNT_W'(1)) r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  sib_coeff_array u_arr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_we      (w_take),
    .i_wr_i    (w_i[IDX_W-1:0]),
    .i_wr_j    (in_byte),
    .i_sign    (w_sign),
    .i_rd_addr (rd_addr),
    .o_rd_code (w_code)
  );

  // Output format mapping of the stored ternary code.
  if (OUT_FMT != 0) begin : g_modq
    always_comb begin
      rd_data = '0;
      unique case (w_code)
        T_POS:   rd_data = OUT_W'(1);
        T_NEG:   rd_data = OUT_W'(Q - 1);
        default: rd_data = '0;
      endcase
    end
  end else begin : g_tern
    assign rd_data = OUT_W'(w_code);
  end

endmodule

// File: tb/tb_sample_in_ball_core.sv
// Randomised scoreboard bench for sample_in_ball_core
// (ternary and mod-q output builds side by side).
module tb_sample_in_ball_core;
  import dilithium_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic       is_err;
    logic [8:0] tau;
    logic [511:0] c;
  } exp_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       abort = 0;
  logic [1:0] lvl = 0;
  logic [7:0] in_byte = 0;
  logic       in_valid = 0;
  logic [7:0] rd_addr;
  logic [7:0] mon_addr = 0;
  logic [7:0] stim_addr = 0;
  logic       mon_sel = 0;
  logic       mon_busy = 0;

  logic        ready0, busy0, done0, err0;
  logic        ready1, busy1, done1, err1;
  logic [1:0]  rd0;
  logic [22:0] rd1;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  assign rd_addr = mon_sel ? mon_addr : stim_addr;

  always #5 clk = ~clk;

  sample_in_ball_core dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ml_dsa_level(lvl), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(ready0), .rd_addr(rd_addr), .rd_data(rd0),
    .busy(busy0), .done(done0), .err(err0)
  );

  sample_in_ball_core #(.OUT_FMT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ml_dsa_level(lvl), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(ready1), .rd_addr(rd_addr), .rd_data(rd1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic check(string name, longint act, longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int tau_of(logic [1:0] l);
    if (l == 2'b01) return 49;
    if (l == 2'b10) return 60;
    return 39;
  endfunction

  function automatic logic [22:0] modq(logic [1:0] t);
    if (t == 2'b01) return 23'd1;
    if (t == 2'b11) return 23'd8380416;
    return 23'd0;
  endfunction

  // Reference SampleInBall over an explicit byte stream.
  function automatic logic [511:0] model(int tau, bq_t s);
    int c[256];
    logic [63:0] h;
    logic [511:0] r;
    int p;
    int j;
    for (int a = 0; a < 256; a++) c[a] = 0;
    for (int b = 0; b < 8; b++) h[8*b +: 8] = s[b];
    p = 8;
    for (int i = 256 - tau; i < 256; i++) begin
      j = 256;
      while (j > i && p < s.size()) begin
        j = int'(s[p]);
        p++;
      end
      if (j <= i) begin
        c[i] = c[j];
        c[j] = h[i - (256 - tau)] ? -1 : 1;
      end
    end
    r = '0;
    for (int a = 0; a < 256; a++)
      r[2*a +: 2] = (c[a] == 1) ? 2'b01 :
                    (c[a] == -1) ? 2'b11 : 2'b00;
    return r;
  endfunction

  // Pad a stream with random index bytes until tau are accepted.
  function automatic bq_t extend(bq_t s, int tau);
    bq_t o;
    int acc;
    logic [7:0] b;
    o = s;
    acc = 0;
    for (int p = 8; p < o.size(); p++)
      if (acc < tau && int'(o[p]) <= 256 - tau + acc) acc++;
    while (acc < tau) begin
      b = 8'($urandom_range(0, 255));
      if (int'(b) <= 256 - tau + acc) acc++;
      o.push_back(b);
    end
    return o;
  endfunction

  function automatic bq_t rand_signs();
    bq_t o;
    for (int b = 0; b < 8; b++) o.push_back(8'($urandom));
    return o;
  endfunction

  task automatic feed(bq_t s);
    int  p = 0;
    int  g = 0;
    logic acc;
    while (p < s.size() && g < 5000) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_byte  = in_valid ? s[p] : 8'($urandom);
      acc = in_valid && ready0;
      @(posedge clk); #1;
      if (acc) p++;
      g++;
    end
    in_valid = 0;
    check("feed_all_bytes", p, s.size());
  endtask

  task automatic do_start(logic [1:0] l);
    start = 1;
    lvl   = l;
    @(posedge clk); #1;
    start = 0;
    lvl   = 2'($urandom);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || mon_busy) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check("scoreboard_drained", exp_q.size() + int'(mon_busy), 0);
  endtask

  task automatic run_job(logic [1:0] l, bq_t s);
    exp_t e;
    e.is_err = 1'b0;
    e.tau    = 9'(tau_of(l));
    e.c      = model(tau_of(l), s);
    exp_q.push_back(e);
    do_start(l);
    feed(s);
    wait_idle();
  endtask

  task automatic count_nz(output int nz0, output int nz1);
    nz0 = 0;
    nz1 = 0;
    for (int a = 0; a < 256; a++) begin
      stim_addr = 8'(a);
      #1;
      if (rd0 != 0) nz0++;
      if (rd1 != 0) nz1++;
    end
  endtask

  // Monitor: pops an expectation on every done/err pulse.
  initial begin
    exp_t e;
    logic [1:0] code;
    int bad0, bad1, nz;
    forever begin
      @(negedge clk);
      if (rst_n && (done0 || err0)) begin
        mon_busy = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_event", {done0, err0}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_err", err0, e.is_err);
          check("event_done", done0, !e.is_err);
          if (!e.is_err) begin
            mon_sel = 1;
            bad0 = 0;
            bad1 = 0;
            nz   = 0;
            for (int a = 0; a < 256; a++) begin
              mon_addr = 8'(a);
              #1;
              code = e.c[2*a +: 2];
              if (rd0 !== code) bad0++;
              if (rd1 !== modq(code)) bad1++;
              if (rd0 != 0) nz++;
            end
            mon_sel = 0;
            check("coeff_ternary_mismatches", bad0, 0);
            check("coeff_modq_mismatches", bad1, 0);
            check("nonzero_count", nz, e.tau);
          end
        end
        mon_busy = 0;
      end
    end
  end

  initial begin
    bq_t  s;
    exp_t e;
    int   nz0, nz1;
    logic [1:0] l;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_in_ready", ready0, 0);
    count_nz(nz0, nz1);
    check("rst_array_tern", nz0, 0);
    check("rst_array_modq", nz1, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // All-zero signs, indices 0..38: every coefficient +1.
    s = {};
    for (int b = 0; b < 8; b++) s.push_back(8'h00);
    for (int k = 0; k < 39; k++) s.push_back(8'(k));
    run_job(2'b00, s);
    count_nz(nz0, nz1);
    check("l0_zero_sign_nz", nz0, 39);

    // Reject 218 at i=217, then j==i=217 with negative sign.
    s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
         8'hDA, 8'hD9};
    s = extend(s, 39);
    run_job(2'b00, s);
    stim_addr = 8'd217;
    #1;
    check("c217_ternary", rd0, 2'b11);
    check("c217_modq", rd1, 8380416);

    // Level 10 random stream.
    s = extend(rand_signs(), 60);
    run_job(2'b10, s);

    // Abort during SAMPLE at k=10, then clean level 01 job.
    do_start(2'b01);
    s = rand_signs();
    for (int k = 0; k < 10; k++) s.push_back(8'h00);
    feed(s);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_busy", busy0, 0);
    check("abort_in_ready", ready0, 0);
    repeat (5) @(posedge clk);
    #1;
    s = extend(rand_signs(), 49);
    run_job(2'b01, s);

    // Illegal level.
    e = '0;
    e.is_err = 1'b1;
    exp_q.push_back(e);
    do_start(2'b11);
    check("err_pulse", err0, 1);
    check("err_busy", busy0, 0);
    check("err_in_ready", ready0, 0);
    wait_idle();

    // Start while busy must not change tau.
    s = extend(rand_signs(), 39);
    e.is_err = 1'b0;
    e.tau    = 9'd39;
    e.c      = model(39, s);
    exp_q.push_back(e);
    do_start(2'b00);
    start = 1;
    lvl   = 2'b10;
    @(posedge clk); #1;
    start = 0;
    check("restart_busy", busy0, 1);
    feed(s);
    wait_idle();

    // Random jobs across levels.
    for (int r = 0; r < 4; r++) begin
      l = 2'($urandom_range(0, 2));
      s = extend(rand_signs(), tau_of(l));
      run_job(l, s);
    end

    // Async reset in the middle of a job.
    do_start(2'b01);
    s = rand_signs();
    feed(s);
    #2;
    rst_n = 0;
    #1;
    check("midrst_busy", busy0, 0);
    check("midrst_in_ready", ready0, 0);
    check("midrst_done", done0, 0);
    check("midrst_err", err0, 0);
    check("midrst_busy_modq", busy1, 0);
    count_nz(nz0, nz1);
    check("midrst_array_tern", nz0, 0);
    check("midrst_array_modq", nz1, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
